// File: rtl/pc_pkg.sv
// pc_pkg -- shared definitions for the program-counter generator.
//   pc_state_e     : FSM state type (ST_RUN, ST_HALT)
//   ALIGN_MASK     : PC bits that must be zero for a legal target
//   is_misaligned  : helper that applies ALIGN_MASK to a target's low bits
package pc_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } pc_state_e;

   localparam logic [1:0] ALIGN_MASK = 2'b11;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return |(lsb & ALIGN_MASK);
   endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras -- circular return-address stack.
//   clk, rst   : clock, synchronous active-high reset (clears count/pointer)
//   push       : write push_data as the new top
//   pop        : discard the top (ignored when empty)
//   push_data  : value written on push
//   top        : current top entry (combinational)
//   empty      : stack holds no entries
//   count      : number of valid entries, saturates at DEPTH
// push+pop on a non-empty stack replaces the top in place (count unchanged);
// push+pop on an empty stack behaves as a plain push.
// DEPTH must be a power of two, at least 2, so the pointer wraps naturally.
module pc_ras #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [XLEN-1:0]  push_data,
   output logic [XLEN-1:0]  top,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [XLEN-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;

   always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_idx = ptr_q;
      if (push && pop && (cnt_q != '0)) begin
         // replace top in place
         wr_en = 1'b1;
      end else if (push) begin
         // on a full stack the pointer wraps onto the oldest entry
         wr_en  = 1'b1;
         wr_idx = ptr_q + 1'b1;
         ptr_d  = ptr_q + 1'b1;
         if (cnt_q != CNT_W'(DEPTH)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (pop && (cnt_q != '0)) begin
         ptr_d = ptr_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // entry contents need no reset: count gates their visibility
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= push_data;
      end
   end

   assign top   = mem_q[ptr_q];
   assign empty = (cnt_q == '0);
   assign count = cnt_q;

endmodule

// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator with source select, optional return
// stack and a sticky halt on misaligned targets.
//   clk, rst   : clock, synchronous active-high reset (wins over everything)
//   stall      : hold all state this cycle
//   select     : next-PC source index; out-of-range picks pc_plus4
//   src        : NSRC flattened XLEN-bit sources, source i at [i*XLEN +: XLEN]
//   ras_push   : push pc_plus4 onto the return stack
//   ras_pop    : redirect to the return-stack top (pc_plus4 when empty)
//   pc         : registered PC
//   pc_plus4   : pc + 4, wraps modulo 2^XLEN
//   halted     : FSM is in HALT
//   misalign   : sticky misaligned-target flag
//   ras_empty  : return stack holds no entries (always 1 without the stack)
// Build option: define PC_RAS_EN to include the return stack (pc_ras).
module pc_gen #(
   parameter int              XLEN      = 32,
   parameter int              NSRC      = 4,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int              RAS_DEPTH = 4,
   localparam int             SEL_W     = $clog2(NSRC)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic [SEL_W-1:0]     select,
   input  logic [NSRC*XLEN-1:0] src,
   input  logic                 ras_push,
   input  logic                 ras_pop,
   output logic [XLEN-1:0]      pc,
   output logic [XLEN-1:0]      pc_plus4,
   output logic                 halted,
   output logic                 misalign,
   output logic                 ras_empty
);
   import pc_pkg::*;

   logic [XLEN-1:0] pc_q, pc_d;
   pc_state_e       state_q, state_d;
   logic            misalign_q, misalign_d;

   logic [XLEN-1:0] src_arr [NSRC];
   logic [XLEN-1:0] sel_val;
   logic [XLEN-1:0] cand;

   logic [XLEN-1:0] ras_top;
   logic            ras_empty_w;
   logic            push_req, pop_req;
   logic            ras_push_en, ras_pop_en;

   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
         assign src_arr[gi] = src[gi*XLEN +: XLEN];
      end
   endgenerate

   assign pc_plus4 = pc_q + XLEN'(4);

   // select values with no matching source fall through to pc_plus4
   always_comb begin
      sel_val = pc_plus4;
      for (int i = 0; i < NSRC; i++) begin
         if (select == SEL_W'(i)) begin
            sel_val = src_arr[i];
         end
      end
   end

`ifdef PC_RAS_EN
   logic [$clog2(RAS_DEPTH+1)-1:0] ras_count_unused;

   pc_ras #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push_en),
      .pop       (ras_pop_en),
      .push_data (pc_plus4),
      .top       (ras_top),
      .empty     (ras_empty_w),
      .count     (ras_count_unused)
   );

   assign push_req = ras_push;
   assign pop_req  = ras_pop;
`else
   logic unused_ras;

   assign ras_top     = '0;
   assign ras_empty_w = 1'b1;
   assign push_req    = 1'b0;
   assign pop_req     = 1'b0;
   assign unused_ras  = ^{ras_push, ras_pop, ras_push_en, ras_pop_en};
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      misalign_d  = misalign_q;
      ras_push_en = 1'b0;
      ras_pop_en  = 1'b0;
      cand        = sel_val;
      if (pop_req) begin
         cand = ras_empty_w ? pc_plus4 : ras_top;
      end
      if ((state_q == ST_RUN) && !stall) begin
         if (is_misaligned(cand[1:0])) begin
            // the stack is left untouched on the way into HALT
            state_d    = ST_HALT;
            misalign_d = 1'b1;
         end else begin
            pc_d        = cand;
            ras_push_en = push_req;
            ras_pop_en  = pop_req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_VEC;
         state_q    <= ST_RUN;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         state_q    <= state_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc        = pc_q;
   assign halted    = (state_q == ST_HALT);
   assign misalign  = misalign_q;
   assign ras_empty = ras_empty_w;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
   localparam int          XLEN  = 32;
   localparam int          NSRC  = 4;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RV    = 32'h100;
`ifdef PC_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 stall = 1'b0;
   logic [1:0]           select = '0;
   logic [NSRC*XLEN-1:0] src = '0;
   logic                 ras_push = 1'b0;
   logic                 ras_pop = 1'b0;
   logic [XLEN-1:0]      pc, pc_plus4;
   logic                 halted, misalign, ras_empty;

   always #5 clk = ~clk;

   pc_gen #(
      .XLEN      (XLEN),
      .NSRC      (NSRC),
      .RESET_VEC (RV),
      .RAS_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .select    (select),
      .src       (src),
      .ras_push  (ras_push),
      .ras_pop   (ras_pop),
      .pc        (pc),
      .pc_plus4  (pc_plus4),
      .halted    (halted),
      .misalign  (misalign),
      .ras_empty (ras_empty)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_src(input logic [31:0] s0, s1, s2, s3);
      src = {s3, s2, s1, s0};
   endtask

   // drive at the falling edge, sample 1 time unit after the rising edge
   task automatic run(input logic r, st, input logic [1:0] sel, input logic pu, po);
      @(negedge clk);
      rst = r; stall = st; select = sel; ras_push = pu; ras_pop = po;
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_pc;
   logic        m_halt, m_mis;
   logic [31:0] m_stack[$];

   task automatic model_step(input logic r, st, input logic [1:0] sel,
                             input logic [31:0] s0, s1, s2, s3,
                             input logic pu, po);
      logic [31:0] p4, c;
      logic [31:0] srcs[4];
      srcs = '{s0, s1, s2, s3};
      if (r) begin
         m_pc = RV; m_halt = 1'b0; m_mis = 1'b0; m_stack.delete();
      end else if (!m_halt && !st) begin
         p4 = m_pc + 32'd4;
         if (RAS_EN && po) c = (m_stack.size() > 0) ? m_stack[$] : p4;
         else              c = srcs[sel];
         if (c % 4 != 0) begin
            m_halt = 1'b1; m_mis = 1'b1;
         end else begin
            if (RAS_EN) begin
               if (po && m_stack.size() > 0) void'(m_stack.pop_back());
               if (pu) begin
                  m_stack.push_back(p4);
                  if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
               end
            end
            m_pc = c;
         end
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        rst;
      logic        stall;
      logic [1:0]  sel;
      logic [31:0] src3;
      logic [31:0] exp_pc;
      logic        exp_halted;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[15];

   initial begin
      logic [31:0] exp_pops[4];

      vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h1030, 32'h100,  1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'h1030, 32'h1000, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 2'd1, 32'h1030, 32'h1010, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 2'd2, 32'h1030, 32'h1020, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 2'd3, 32'h1030, 32'h1030, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 2'd0, 32'h1030, 32'h1030, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 2'd1, 32'h1030, 32'h1030, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 2'd2, 32'h1030, 32'h1030, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 2'd1, 32'h1030, 32'h1010, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 2'd3, 32'h2002, 32'h1010, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 2'd0, 32'h2002, 32'h1010, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 2'd2, 32'h1030, 32'h1010, 1'b1, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 2'd2, 32'h1030, 32'h100,  1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 2'd2, 32'h1030, 32'h1020, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 2'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0};

      for (int i = 0; i < 15; i++) begin
         set_src(32'h1000, 32'h1010, 32'h1020, vecs[i].src3);
         run(vecs[i].rst, vecs[i].stall, vecs[i].sel, 1'b0, 1'b0);
         $display("vec %0d: rst=%0b stall=%0b sel=%0d pc=0x%0h halted=%0b misalign=%0b",
                  i, vecs[i].rst, vecs[i].stall, vecs[i].sel, pc, halted, misalign);
         check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
         check($sformatf("vec%0d_halted", i), {31'b0, halted}, {31'b0, vecs[i].exp_halted});
         check($sformatf("vec%0d_misalign", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
         check($sformatf("vec%0d_ras_empty", i), {31'b0, ras_empty}, 32'd1);
      end
      // pc_plus4 wraps at the top of the address space
      check("pc_plus4_wrap", pc_plus4, 32'h0);

`ifdef PC_RAS_EN
      // call / return / return on empty
      set_src(32'h40, 32'h800, 32'h0, 32'h0);
      run(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      run(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      $display("ras: pc=0x%0h", pc);
      check("ras_start_pc", pc, 32'h40);
      run(1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
      $display("ras push: pc=0x%0h empty=%0b", pc, ras_empty);
      check("ras_call_pc", pc, 32'h800);
      check("ras_call_empty", {31'b0, ras_empty}, 32'd0);
      run(1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
      $display("ras pop: pc=0x%0h empty=%0b", pc, ras_empty);
      check("ras_ret_pc", pc, 32'h44);
      check("ras_ret_empty", {31'b0, ras_empty}, 32'd1);
      run(1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
      $display("ras pop empty: pc=0x%0h", pc);
      check("ras_pop_empty_pc", pc, 32'h48);

      // overflow: five pushes into four entries, oldest lost
      run(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         set_src(32'h1000 * k, 32'h0, 32'h0, 32'h0);
         run(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
         $display("ovf push %0d: pc=0x%0h", k, pc);
      end
      exp_pops = '{32'h4004, 32'h3004, 32'h2004, 32'h1004};
      for (int k = 0; k < 4; k++) begin
         run(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
         $display("ovf pop %0d: pc=0x%0h empty=%0b", k, pc, ras_empty);
         check($sformatf("ovf_pop%0d_pc", k), pc, exp_pops[k]);
         check($sformatf("ovf_pop%0d_empty", k), {31'b0, ras_empty}, (k == 3) ? 32'd1 : 32'd0);
      end
`else
      // push/pop have no effect without the stack
      set_src(32'h40, 32'h800, 32'h0, 32'h0);
      run(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      run(1'b0, 1'b0, 2'd1, 1'b1, 1'b1);
      $display("noras push+pop: pc=0x%0h empty=%0b", pc, ras_empty);
      check("noras_pc1", pc, 32'h800);
      check("noras_empty", {31'b0, ras_empty}, 32'd1);
      run(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      $display("noras pop: pc=0x%0h", pc);
      check("noras_pc2", pc, 32'h40);
`endif

      // ---------------- randomized against the model ----------------
      for (int i = 0; i < 400; i++) begin
         logic        r, st, pu, po;
         logic [1:0]  sel;
         logic [31:0] s[4];
         r   = (i == 0) || ($urandom_range(0, 99) < 3);
         st  = ($urandom_range(0, 99) < 15);
         sel = 2'($urandom_range(0, 3));
         pu  = ($urandom_range(0, 99) < 30);
         po  = ($urandom_range(0, 99) < 30);
         for (int j = 0; j < 4; j++) begin
            s[j] = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 99) < 2) s[j] = s[j] | 32'd2;
         end
         set_src(s[0], s[1], s[2], s[3]);
         model_step(r, st, sel, s[0], s[1], s[2], s[3], pu, po);
         run(r, st, sel, pu, po);
         $display("rnd %0d: rst=%0b stall=%0b sel=%0d push=%0b pop=%0b pc=0x%0h halted=%0b",
                  i, r, st, sel, pu, po, pc, halted);
         check("rnd_pc", pc, m_pc);
         check("rnd_pc_plus4", pc_plus4, m_pc + 32'd4);
         check("rnd_halted", {31'b0, halted}, {31'b0, m_halt});
         check("rnd_misalign", {31'b0, misalign}, {31'b0, m_mis});
         check("rnd_ras_empty", {31'b0, ras_empty}, (m_stack.size() == 0) ? 32'd1 : 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
